demux_rr_dispatcher: RTL and testbench
======================================

// Module: demux_rr_dispatcher
// PURPOSE
//  Stream dispatcher that sequences a 1-to-N demux datapath (N = 2**snum).
//  Accepts input words on a valid/ready handshake and steers each one to an output.
//  Two steering modes: round-robin over outputs that can accept, or fixed to a selected output.
//  Each output has a one-deep holding register, so the demux path never drops or duplicates a word.
//  A flush sequence stops intake and reports when all held words have drained.
// PARAMETERS
//  width  8  data word width in bits
//  snum   1  select width; number of outputs N = 2**snum
// PORTS
//  clk        input   1          rising-edge clock, single clock domain
//  rst        input   1          synchronous reset, active-high
//  i          input   width      input data word
//  i_valid    input   1          input word present
//  i_ready    output  1          dispatcher accepts i this cycle
//  mode       input   1          0 = round-robin, 1 = fixed (steer to sel)
//  sel        input   snum       target output in fixed mode
//  flush      input   1          request drain: stop intake until all outputs empty
//  o          output  N*width    output words, channel k at o[k*width +: width]
//  o_valid    output  N          channel k holds a word
//  o_ready    input   N          downstream k takes its word
//  flush_done output  1          one-cycle pulse: flush complete
//  ptr        output  snum       round-robin pointer (debug/visibility)
// BEHAVIOUR
//  Reset (rst=1 at clk edge):
//  - o_valid=0, o=0, ptr=0, flush_done=0, state=RUN. Held words are discarded.
//  Holding register k:
//  - can_acc[k] = ~o_valid[k] | o_ready[k]  (pass-through ready).
//  - Output transfer when o_valid[k] & o_ready[k].
//  - Load: o_valid[k]=1 and o[k] <= i at the edge when the input handshake targets k.
//  - Clear: o_valid[k]=0 after a transfer with no new load.
//  Target select (combinational):
//  - mode=1: tgt = sel. Eligible iff can_acc[sel].
//  - mode=0: tgt = first k scanning ptr, ptr+1, ... (mod N) with can_acc[k]=1.
//    None eligible => no target.
//  - i_ready = (state==RUN) & ~flush & target eligible.
//  - i_ready does not depend on i_valid.
//  Handshake and latency:
//  - Accept when i_valid & i_ready.
//  - Word appears with o_valid[tgt]=1 on the following cycle (latency 1).
//  - i must be held stable while i_valid=1 & i_ready=0.
//  Pointer:
//  - On accept in mode=0: ptr <= (tgt+1) mod N (wraps N-1 -> 0).
//  - On accept in mode=1: ptr <= (sel+1) mod N. Round-robin then resumes fairly after a mode switch.
//  - No accept: ptr holds.
//  - Mode changes take effect on the next accept decision. No word in flight is re-steered.
//  FSM states RUN, DRAIN, DONE:
//  - RUN: flush=1 -> DRAIN. A word offered in the same cycle as flush is NOT accepted.
//  - DRAIN: i_ready=0. When o_valid==0 (all empty) -> DONE.
//  - DONE: flush_done=1 for exactly this one cycle, i_ready=0. Always -> RUN.
//    If flush is still high in RUN, the FSM re-enters DRAIN.
//  - Flush with all outputs already empty: RUN -> DRAIN -> DONE. flush_done comes 2 cycles after flush.
//  Simultaneous events:
//  - Transfer and load on the same channel in one cycle: new word replaces old; o_valid stays 1.
//  - rst overrides everything, including DRAIN/DONE and a pending accept.
// TESTING  (width=8, snum=1)
//  1 Reset: rst=1 for 2 cycles -> o_valid=2'b00, ptr=0, i_ready=1 (mode=0, no flush), flush_done=0.
//  2 RR streaming: o_ready=2'b11, mode=0, send A0,B0,C0,D0 back-to-back
//    -> ch0 gets A0, ch1 B0, ch0 C0, ch1 D0, each 1 cycle after accept; i_ready stays 1.
//  3 RR skip: o_ready=2'b10 with ch0 holding 11, ptr=0, send 22,33
//    -> both go to ch1 in successive cycles; ch0 keeps 11; ptr=0 after each accept.
//  4 Fixed stall: mode=1, sel=1, o_ready=2'b00, send 5A then 5B
//    -> 5A held on ch1, i_ready=0 with 5B pending; raise o_ready[1] -> 5B loads next cycle.
//  5 Flush: ch0 holds AA, o_ready=0, flush=1 with i_valid=1 (data 77)
//    -> 77 not accepted, i_ready=0 in DRAIN; o_ready[0]=1 -> AA transfers,
//    flush_done pulses 1 cycle later, then RUN.
//  6 Reset mid-op: both channels valid, state DRAIN, assert rst
//    -> next edge o_valid=0, ptr=0, state RUN, no flush_done pulse.

Source files
------------

// File: rtl/demux_rr_dispatcher.sv
// Stream dispatcher for a 1-to-N demux: steers each accepted word into a one-deep
// per-output holding register, round-robin or fixed, with a flush/drain sequence.
module demux_rr_dispatcher #(
  parameter int width = 8,
  parameter int snum  = 1,
  localparam int n    = 2 ** snum
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [width-1:0]     i,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic                 mode,
  input  logic [snum-1:0]      sel,
  input  logic                 flush,
  output logic [n*width-1:0]   o,
  output logic [n-1:0]         o_valid,
  input  logic [n-1:0]         o_ready,
  output logic                 flush_done,
  output logic [snum-1:0]      ptr,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            st_q, st_d;
  logic [n-1:0]      can_acc;
  logic [snum-1:0]   tgt;
  logic [snum-1:0]   scan_idx;
  logic              elig;
  logic              accept;

  // Handshakes: a word moves only in a cycle where valid & ready are both high at
  // the clock edge; ready never looks at valid, and a stalled word must stay stable.
  assign can_acc = ~o_valid | o_ready;

  always_comb begin
    tgt      = ptr;
    elig     = 1'b0;
    scan_idx = ptr;
    if (mode) begin
      tgt  = sel;
      elig = can_acc[sel];
    end else begin
      for (int j = 0; j < n; j++) begin
        scan_idx = ptr + snum'(j);
        if (!elig && can_acc[scan_idx]) begin
          tgt  = scan_idx;
          elig = 1'b1;
        end
      end
    end
  end

  assign i_ready    = (st_q == RUN) && !flush && elig;
  assign accept     = i_valid && i_ready;
  assign flush_done = (st_q == DONE);
  assign state      = st_q;

  // A load wins over a same-cycle transfer, so the channel stays valid with the new word.
  always_ff @(posedge clk) begin
    if (rst) begin
      o       <= '0;
      o_valid <= '0;
      ptr     <= '0;
    end else begin
      for (int k = 0; k < n; k++) begin
        if (accept && (tgt == snum'(k))) begin
          o[k*width +: width] <= i;
          o_valid[k]          <= 1'b1;
        end else if (o_ready[k]) begin
          o_valid[k] <= 1'b0;
        end
      end
      if (accept) begin
        ptr <= tgt + snum'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= RUN;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      RUN:     if (flush) st_d = DRAIN;
      DRAIN:   if (o_valid == '0) st_d = DONE;
      DONE:    st_d = RUN;
      default: st_d = RUN;
    endcase
  end

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Bench for demux_rr_dispatcher (width=8, snum=1): directed scenarios plus random
// traffic, all checked against a behavioural model and per-channel expected queues.
module tb_demux_rr_dispatcher;
  localparam int W = 8;
  localparam int S = 1;
  localparam int N = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [W-1:0]     i;
  logic             i_valid;
  logic             i_ready;
  logic             mode;
  logic [S-1:0]     sel;
  logic             flush;
  logic [N*W-1:0]   o;
  logic [N-1:0]     o_valid;
  logic [N-1:0]     o_ready;
  logic             flush_done;
  logic [S-1:0]     ptr;
  logic [1:0]       state;

  always #5 clk = ~clk;

  demux_rr_dispatcher #(.width(W), .snum(S)) dut (
    .clk(clk), .rst(rst), .i(i), .i_valid(i_valid), .i_ready(i_ready),
    .mode(mode), .sel(sel), .flush(flush), .o(o), .o_valid(o_valid),
    .o_ready(o_ready), .flush_done(flush_done), .ptr(ptr), .state(state)
  );

  int total = 0;
  int bad   = 0;

  // model: per-channel held flag/word, pointer, flush phase (0 run, 1 drain, 2 done)
  int           mv[N];
  logic [W-1:0] md[N];
  int           mp;
  int           mst;
  bit           last_acc;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  // One clock: check DUT against model (when chk), then advance model over the edge.
  task automatic cycle(input bit chk);
    int           can[N];
    int           tgt;
    int           kk;
    bit           elig;
    bit           acc;
    bit           all_empty;
    logic [W-1:0] got;
    logic [W-1:0] want;
    #1;
    for (int k = 0; k < N; k++) can[k] = (mv[k] == 0 || o_ready[k]) ? 1 : 0;
    elig = 1'b0;
    tgt  = 0;
    if (mode) begin
      tgt  = int'(sel);
      elig = (can[tgt] != 0);
    end else begin
      for (int j = 0; j < N; j++) begin
        kk = (mp + j) % N;
        if (!elig && can[kk] != 0) begin
          tgt  = kk;
          elig = 1'b1;
        end
      end
    end
    elig = elig && (mst == 0) && !flush;
    if (chk) begin
      total++;
      if (i_ready !== elig) begin
        bad++;
        $display("FAIL i_ready got=%b exp=%b t=%0t", i_ready, elig, $time);
      end
      for (int k = 0; k < N; k++) begin
        total++;
        if (o_valid[k] !== (mv[k] != 0)) begin
          bad++;
          $display("FAIL o_valid[%0d] got=%b exp=%b t=%0t", k, o_valid[k], mv[k] != 0, $time);
        end
        if (mv[k] != 0) begin
          total++;
          if (o[k*W +: W] !== md[k]) begin
            bad++;
            $display("FAIL o[%0d] got=%h exp=%h t=%0t", k, o[k*W +: W], md[k], $time);
          end
        end
      end
      total++;
      if (ptr !== S'(mp)) begin
        bad++;
        $display("FAIL ptr got=%0d exp=%0d t=%0t", ptr, mp, $time);
      end
      total++;
      if (flush_done !== (mst == 2)) begin
        bad++;
        $display("FAIL flush_done got=%b exp=%b t=%0t", flush_done, mst == 2, $time);
      end
      for (int k = 0; k < N; k++) begin
        if (o_valid[k] === 1'b1 && o_ready[k] === 1'b1) begin
          got = o[k*W +: W];
          total++;
          if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
            bad++;
            $display("FAIL sb_unexpected ch=%0d got=%h exp=none t=%0t", k, got, $time);
          end else begin
            want = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            if (got !== want) begin
              bad++;
              $display("FAIL sb_data ch=%0d got=%h exp=%h t=%0t", k, got, want, $time);
            end
          end
        end
      end
    end
    acc       = i_valid && elig;
    all_empty = 1'b1;
    for (int k = 0; k < N; k++) if (mv[k] != 0) all_empty = 1'b0;
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        mv[k] = 0;
        md[k] = '0;
      end
      mp = 0;
      mst = 0;
      last_acc = 1'b0;
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      for (int k = 0; k < N; k++) begin
        if (acc && tgt == k) begin
          mv[k] = 1;
          md[k] = i;
          if (k == 0) exp_q0.push_back(i);
          else exp_q1.push_back(i);
        end else if (mv[k] != 0 && o_ready[k]) begin
          mv[k] = 0;
        end
      end
      if (acc) mp = (tgt + 1) % N;
      case (mst)
        0: if (flush) mst = 1;
        1: if (all_empty) mst = 2;
        default: mst = 0;
      endcase
      last_acc = acc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i = '0; i_valid = 1'b0; mode = 1'b0; sel = '0; flush = 1'b0; o_ready = '0;
    cycle(1'b0);
    cycle(1'b0);
    rst = 1'b0;
    #1;
    total++; if (o_valid !== 2'b00) begin bad++; $display("FAIL rst_o_valid got=%b exp=00", o_valid); end
    total++; if (ptr !== 1'b0) begin bad++; $display("FAIL rst_ptr got=%0d exp=0", ptr); end
    total++; if (i_ready !== 1'b1) begin bad++; $display("FAIL rst_i_ready got=%b exp=1", i_ready); end
    total++; if (flush_done !== 1'b0) begin bad++; $display("FAIL rst_flush_done got=%b exp=0", flush_done); end
    cycle(1'b1);
  endtask

  task automatic test_rr_stream();
    logic [W-1:0] d[4];
    d[0] = 8'hA0; d[1] = 8'hB0; d[2] = 8'hC0; d[3] = 8'hD0;
    o_ready = 2'b11; mode = 1'b0;
    for (int j = 0; j < 4; j++) begin
      i = d[j]; i_valid = 1'b1;
      #1;
      total++; if (i_ready !== 1'b1) begin bad++; $display("FAIL rr_ready j=%0d got=%b exp=1", j, i_ready); end
      cycle(1'b1);
      #1;
      total++;
      if (o_valid[j % 2] !== 1'b1 || o[(j % 2)*W +: W] !== d[j]) begin
        bad++;
        $display("FAIL rr_steer j=%0d got=%b/%h exp=1/%h", j, o_valid[j % 2], o[(j % 2)*W +: W], d[j]);
      end
    end
    i_valid = 1'b0;
    cycle(1'b1);
    cycle(1'b1);
  endtask

  task automatic test_rr_skip();
    o_ready = 2'b00; mode = 1'b1; sel = 1'b0; i = 8'h11; i_valid = 1'b1;
    cycle(1'b1);
    sel = 1'b1; i = 8'h99;
    cycle(1'b1);
    mode = 1'b0; o_ready = 2'b10; i = 8'h22;
    #1;
    total++; if (i_ready !== 1'b1) begin bad++; $display("FAIL skip_ready got=%b exp=1", i_ready); end
    cycle(1'b1);
    #1;
    total++;
    if (o[15:8] !== 8'h22 || o[7:0] !== 8'h11 || ptr !== 1'b0) begin
      bad++; $display("FAIL skip_22 got=%h/%h/%0d exp=22/11/0", o[15:8], o[7:0], ptr);
    end
    i = 8'h33;
    cycle(1'b1);
    #1;
    total++;
    if (o[15:8] !== 8'h33 || o[7:0] !== 8'h11 || ptr !== 1'b0) begin
      bad++; $display("FAIL skip_33 got=%h/%h/%0d exp=33/11/0", o[15:8], o[7:0], ptr);
    end
    i_valid = 1'b0; o_ready = 2'b11;
    cycle(1'b1);
    cycle(1'b1);
  endtask

  task automatic test_fixed_stall();
    mode = 1'b1; sel = 1'b1; o_ready = 2'b00; i = 8'h5A; i_valid = 1'b1;
    cycle(1'b1);
    i = 8'h5B;
    #1;
    total++; if (i_ready !== 1'b0) begin bad++; $display("FAIL stall_ready got=%b exp=0", i_ready); end
    cycle(1'b1);
    #1;
    total++;
    if (i_ready !== 1'b0 || o[15:8] !== 8'h5A) begin
      bad++; $display("FAIL stall_hold got=%b/%h exp=0/5a", i_ready, o[15:8]);
    end
    o_ready = 2'b10;
    #1;
    total++; if (i_ready !== 1'b1) begin bad++; $display("FAIL stall_release got=%b exp=1", i_ready); end
    cycle(1'b1);
    #1;
    total++;
    if (o_valid[1] !== 1'b1 || o[15:8] !== 8'h5B) begin
      bad++; $display("FAIL stall_5b got=%b/%h exp=1/5b", o_valid[1], o[15:8]);
    end
    i_valid = 1'b0; o_ready = 2'b11;
    cycle(1'b1);
    cycle(1'b1);
  endtask

  task automatic test_flush();
    mode = 1'b1; sel = 1'b0; o_ready = 2'b00; i = 8'hAA; i_valid = 1'b1;
    cycle(1'b1);
    flush = 1'b1; i = 8'h77;
    #1;
    total++; if (i_ready !== 1'b0) begin bad++; $display("FAIL flush_block got=%b exp=0", i_ready); end
    cycle(1'b1);
    flush = 1'b0;
    #1;
    total++; if (i_ready !== 1'b0) begin bad++; $display("FAIL drain_ready got=%b exp=0", i_ready); end
    cycle(1'b1);
    o_ready = 2'b01;
    cycle(1'b1);
    #1;
    total++;
    if (flush_done !== 1'b0 || o_valid !== 2'b00) begin
      bad++; $display("FAIL drain_empty got=%b/%b exp=0/00", flush_done, o_valid);
    end
    cycle(1'b1);
    #1;
    total++;
    if (flush_done !== 1'b1 || i_ready !== 1'b0) begin
      bad++; $display("FAIL done_pulse got=%b/%b exp=1/0", flush_done, i_ready);
    end
    cycle(1'b1);
    #1;
    total++;
    if (flush_done !== 1'b0 || i_ready !== 1'b1) begin
      bad++; $display("FAIL back_to_run got=%b/%b exp=0/1", flush_done, i_ready);
    end
    cycle(1'b1);
    #1;
    total++; if (o[7:0] !== 8'h77) begin bad++; $display("FAIL post_flush got=%h exp=77", o[7:0]); end
    i_valid = 1'b0; o_ready = 2'b11;
    cycle(1'b1);
  endtask

  task automatic test_reset_mid();
    o_ready = 2'b00; mode = 1'b1; sel = 1'b1; i = 8'hC1; i_valid = 1'b1;
    cycle(1'b1);
    sel = 1'b0; i = 8'hC2;
    cycle(1'b1);
    i_valid = 1'b0; flush = 1'b1;
    cycle(1'b1);
    flush = 1'b0; rst = 1'b1;
    cycle(1'b1);
    rst = 1'b0;
    #1;
    total++;
    if (o_valid !== 2'b00 || ptr !== 1'b0 || state !== 2'd0 || flush_done !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset got=%b/%0d/%0d/%b exp=00/0/0/0", o_valid, ptr, state, flush_done);
    end
    cycle(1'b1);
    #1;
    total++; if (flush_done !== 1'b0) begin bad++; $display("FAIL mid_reset_pulse got=%b exp=0", flush_done); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if (!i_valid || last_acc) begin
        i_valid = ($urandom_range(0, 3) != 0);
        i = W'($urandom);
      end
      mode    = ($urandom_range(0, 3) == 0);
      sel     = S'($urandom_range(0, N - 1));
      o_ready = N'($urandom);
      flush   = ($urandom_range(0, 24) == 0);
      rst     = ($urandom_range(0, 99) == 0);
      cycle(1'b1);
    end
    rst = 1'b0; flush = 1'b0; i_valid = 1'b0; o_ready = 2'b11;
    for (int c = 0; c < 4; c++) cycle(1'b1);
    total++;
    if (exp_q0.size() + exp_q1.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover got=%0d exp=0", exp_q0.size() + exp_q1.size());
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      mv[k] = 0;
      md[k] = '0;
    end
    mp = 0; mst = 0; last_acc = 1'b0;
    test_reset();
    test_rr_stream();
    test_rr_skip();
    test_fixed_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
